// File: rtl/stream_compare.sv
// Compares two valid-qualified beat streams over a programmed run length and reports
// whether they match within a per-channel tolerance, how many beats mismatched, and the first mismatching beat.
module stream_compare #(
  parameter int DATA_W    = 8,
  parameter int CHANNELS  = 1,
  parameter int TOLERANCE = 0,
  parameter int CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CNT_W-1:0]             length,
  input  logic                         a_valid,
  input  logic [CHANNELS*DATA_W-1:0]   a_data,
  output logic                         a_ready,
  input  logic                         b_valid,
  input  logic [CHANNELS*DATA_W-1:0]   b_data,
  output logic                         b_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         result,
  output logic [CNT_W-1:0]             mismatch_count,
  output logic [CNT_W-1:0]             first_idx,
  output logic                         first_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Wide enough that any int TOLERANCE compares exactly against a DATA_W+1 difference.
  localparam int EXT_W = DATA_W + 33;
  localparam logic [EXT_W-1:0] TOL_EXT = EXT_W'(TOLERANCE);

  state_t state, state_next;
  logic [CNT_W-1:0] len, idx;
  logic [CHANNELS-1:0] ch_mis;
  logic xfer, accept, beat_mis, last_beat;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DATA_W:0] ea, eb, diff;
    assign ea         = {1'b0, a_data[gi*DATA_W +: DATA_W]};
    assign eb         = {1'b0, b_data[gi*DATA_W +: DATA_W]};
    assign diff       = (ea >= eb) ? (ea - eb) : (eb - ea);
    assign ch_mis[gi] = EXT_W'(diff) > TOL_EXT;
  end

  assign beat_mis  = |ch_mis;
  assign xfer      = (state == RUN) && a_valid && b_valid;
  assign accept    = start && (state != RUN);
  assign last_beat = (idx == len - CNT_W'(1));
  assign a_ready   = xfer;
  assign b_ready   = xfer;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (length == '0) ? DONE : RUN;
      RUN:        if (xfer && last_beat) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len            <= '0;
      idx            <= '0;
      result         <= 1'b0;
      mismatch_count <= '0;
      first_idx      <= '0;
      first_valid    <= 1'b0;
    end else if (accept) begin
      len            <= length;
      idx            <= '0;
      result         <= 1'b0;
      mismatch_count <= '0;
      first_valid    <= 1'b0;
    end else if (xfer) begin
      idx <= idx + CNT_W'(1);
      if (beat_mis) begin
        result <= 1'b1;
        if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
        if (!first_valid) begin
          first_idx   <= idx;
          first_valid <= 1'b1;
        end
      end
    end
  end

endmodule
